register_pipeline_receiver: RTL
===============================

# register_pipeline_receiver

Receive-side companion for a `register_pipeline` instance of depth LATENCY. It drives the pipeline's `enable`, tracks which pipeline stages carry real words with a shadow valid-tag chain, and captures each valid word at the pipeline output into a DEPTH-entry FIFO. It exposes valid/ready handshakes upstream and downstream. It never shifts a valid word off the pipeline end unless the word can be stored, so downstream backpressure cannot drop data.

## Interface
- WIDTH, 16, data width; must equal the pipeline WIDTH.
- LATENCY, 8, stage count of the attached pipeline (its SIZE); ≥1.
- DEPTH, 4, FIFO entries; power of two, ≥2.

- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low; clears tags, counters and FIFO pointers.
- in_valid  input  1  upstream word present. The upstream data wires go directly to pipeline `datain`, not through this block.
- in_ready  output  1  upstream word accepted on an edge where in_valid && in_ready.
- pipe_enable  output  1  drives pipeline `enable`.
- pipe_dataout  input  WIDTH  pipeline `dataout`.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accepts the head word.
- out_data  output  WIDTH  FIFO head word; valid only while out_valid is high.
- inflight  output  $clog2(LATENCY+1)  count of valid tags in the pipeline.
- fifo_count  output  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- Tag chain `tag[0..LATENCY-1]` mirrors the pipeline. On an edge with pipe_enable, `tag[0] <= in_valid` and `tag[i+1] <= tag[i]`. With pipe_enable low, the tags hold.
- Pipeline data registers have no reset. Garbage in them is ignored because every tag resets to 0.
- can_shift = !tag[LATENCY-1] || (fifo_count < DEPTH) || (out_valid && out_ready).
- in_ready = can_shift. in_ready does not depend on in_valid, so there is no combinational loop.
- pipe_enable = can_shift && (in_valid || inflight != 0). When no input is arriving, the pipeline keeps shifting bubbles in until it is drained. It idles (enable low) when inflight == 0 and in_valid is low.
- Capture: on an edge with pipe_enable && tag[LATENCY-1], pipe_dataout is written to the FIFO tail.
- Read: on an edge with out_valid && out_ready, the FIFO head pops.
- Read and write on the same edge are both performed; fifo_count is unchanged.
- inflight update per edge: +1 if (pipe_enable && in_valid); −1 if (pipe_enable && tag[LATENCY-1]); both cancel. inflight never exceeds LATENCY.
- FIFO: register array with wrapping pointers of width log2(DEPTH). The count range is 0..DEPTH. out_data is the combinational read of the head entry.
- There is no state machine beyond the tag chain, counters and pointers. All states are reachable only by the rules above.

## Timing
- Reset values (reset low, asynchronous): tag = 0, inflight = 0, fifo_count = 0, out_valid = 0, in_ready = 1, pipe_enable = in_valid.
- Latency, no stalls: a word accepted at edge k is at pipe_dataout after edge k+LATENCY−1. It is captured at edge k+LATENCY and out_valid is high after edge k+LATENCY. That is LATENCY+1 edges from acceptance to FIFO.
- Throughput: 1 word/cycle while out_ready stays high.
- Stall: FIFO full, tag[LATENCY-1] = 1 and no read gives in_ready = 0 and pipe_enable = 0. The pipeline and tags freeze. Any word held at the end is preserved.
- FIFO full, tag end set, and out_ready high in the same cycle: the shift proceeds and the write and read happen on the same edge.
- Combinational paths are out_ready → in_ready and out_ready → pipe_enable. These paths are accepted.
- Reset mid-operation: all in-flight and buffered words are discarded. out_valid drops immediately, without waiting for a clock edge.

## Test plan
- LATENCY = 8, DEPTH = 4, out_ready = 1. Send the single word 0xA5A5 at edge 0. Required: out_valid rises after edge 8 with out_data = 0xA5A5; pipe_enable drops after the drain, once inflight = 0.
- Send the streaming words 1..20 back-to-back with out_ready = 1. Required: out_data delivers 1..20 in order on consecutive cycles; in_ready stays high throughout.
- Hold out_ready = 0 while streaming words 1..20. Required: fifo_count reaches 4 and inflight reaches 8; in_ready then drops and no word is lost. Raising out_ready afterwards yields 1..12 in order, each word exactly once.
- Keep the FIFO full with a valid word at the pipeline end, then pulse out_ready for 1 cycle. Required: exactly one pop and one capture; fifo_count stays at 4; pipe_enable is high for that cycle only.
- Assert reset low asynchronously mid-stream with inflight = 5 and fifo_count = 3. Required: out_valid = 0, fifo_count = 0 and inflight = 0 immediately. After reset is released, a new word 0x1234 emerges after LATENCY+1 edges and no stale words appear.
- LATENCY = 1, DEPTH = 2, with random in_valid and out_ready over 10k cycles. Required: the scoreboard shows in-order output, no drops and no duplicates.

Source files
------------

// File: rtl/register_pipeline_receiver.sv
// Receive-side controller for a register_pipeline: drives the pipeline enable,
// shadows stage validity with a tag chain and lands valid words in a small FIFO.
module register_pipeline_receiver #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 8,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         pipe_enable,
  input  logic [WIDTH-1:0]             pipe_dataout,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(LATENCY+1)-1:0] inflight,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int IW = $clog2(LATENCY + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [LATENCY-1:0] tag;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               tag_end;
  logic               fifo_full;
  logic               pop;
  logic               push;
  logic               take;
  logic               can_shift;

  // The end word may only leave the pipeline if the FIFO has (or is making) room.
  always_comb begin
    tag_end     = tag[LATENCY-1];
    fifo_full   = (fifo_count == CW'(DEPTH));
    pop         = out_valid && out_ready;
    can_shift   = !tag_end || !fifo_full || pop;
    pipe_enable = can_shift && (in_valid || (inflight != '0));
    push        = pipe_enable && tag_end;
    take        = pipe_enable && in_valid;
  end

  assign in_ready  = can_shift;
  assign out_valid = (fifo_count != '0);
  assign out_data  = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its predecessor's pre-edge value, exactly like the pipeline it shadows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag <= '0;
    end else if (pipe_enable) begin
      tag[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) tag[i] <= tag[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
    end else begin
      case ({take, push})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // NOTE: storage is deliberately not reset; fifo_count gates out_valid, so
  // stale entries are never observable and the array stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pipe_dataout;
  end

endmodule
